// File: rtl/dm_pkg.sv
// dm_pkg: shared encodings for the DMI front end.
//   - DMI op and response-status encodings
//   - DM register address constants
//   - front-end FSM state type
//   - address classification helpers (lock set, implemented set)
package dm_pkg;

   localparam logic [1:0] DMI_OP_NOP    = 2'd0;
   localparam logic [1:0] DMI_OP_READ   = 2'd1;
   localparam logic [1:0] DMI_OP_WRITE  = 2'd2;
   localparam logic [1:0] DMI_OP_RSVD   = 2'd3;

   localparam logic [1:0] DMI_RSP_OK     = 2'd0;
   localparam logic [1:0] DMI_RSP_FAILED = 2'd2;
   localparam logic [1:0] DMI_RSP_BUSY   = 2'd3;

   localparam logic [31:0] DATA0      = 32'h04;
   localparam logic [31:0] DATA11     = 32'h0F;
   localparam logic [31:0] DMCONTROL  = 32'h10;
   localparam logic [31:0] DMSTATUS   = 32'h11;
   localparam logic [31:0] ABSTRACTCS = 32'h16;
   localparam logic [31:0] COMMAND    = 32'h17;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } dm_state_e;

   // Registers that an executing abstract command owns; writes are refused
   // while cmd_busy is high.
   function automatic logic is_lock_addr(input logic [31:0] a);
      return ((a >= DATA0) && (a <= DATA11)) || (a == ABSTRACTCS) || (a == COMMAND);
   endfunction

   // Registers this DM actually implements.
   function automatic logic is_impl_addr(input logic [31:0] a);
      return is_lock_addr(a) || (a == DMCONTROL) || (a == DMSTATUS);
   endfunction

endpackage

// File: rtl/dm_rsp_reg.sv
// dm_rsp_reg: response holding register (data + status).
//   clk      rising-edge clock
//   reset    async active-low reset, clears data and status to 0
//   load     capture d_data/d_status this cycle
//   d_data   next response data      d_status  next response status
//   q_data   held response data      q_status  held response status
module dm_rsp_reg #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] d_data,
   input  logic [1:0]   d_status,
   output logic [W-1:0] q_data,
   output logic [1:0]   q_status
);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         q_data   <= '0;
         q_status <= '0;
      end else if (load) begin
         q_data   <= d_data;
         q_status <= d_status;
      end
   end

endmodule

// File: rtl/dm_dmi_frontend.sv
// dm_dmi_frontend: Debug Module DMI front end.
// Accepts one DMI request at a time (valid/ready), spends exactly one ACCESS
// cycle driving a read or write strobe into the DM register file, then holds
// a registered response until the DTM takes it.
//   clk, reset            clock, async active-low reset
//   dmi_req_*             request channel from the DTM
//   dmi_rsp_*             response channel to the DTM
//   cmd_busy              abstract command executing (locks data/abstractcs/command writes)
//   reg_addr/wen/ren/wdata/rdata  register-file access port
// Optional build macro: DMI_ADDR_CHECK_EN -- reject addresses outside the
// implemented register set with status FAILED (takes priority over BUSY).
module dm_dmi_frontend
   import dm_pkg::*;
#(
   parameter int ABITS    = 7,
   parameter int XLEN_DMI = 32
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                dmi_req_valid,
   output logic                dmi_req_ready,
   input  logic [ABITS-1:0]    dmi_req_addr,
   input  logic [1:0]          dmi_req_op,
   input  logic [XLEN_DMI-1:0] dmi_req_data,
   output logic                dmi_rsp_valid,
   input  logic                dmi_rsp_ready,
   output logic [XLEN_DMI-1:0] dmi_rsp_data,
   output logic [1:0]          dmi_rsp_status,
   input  logic                cmd_busy,
   output logic [ABITS-1:0]    reg_addr,
   output logic                reg_wen,
   output logic                reg_ren,
   output logic [XLEN_DMI-1:0] reg_wdata,
   input  logic [XLEN_DMI-1:0] reg_rdata
);

   dm_state_e           state;
   logic [ABITS-1:0]    addr_q;
   logic [1:0]          op_q;
   logic [XLEN_DMI-1:0] wdata_q;

   logic                accept;
   logic                in_access;
   logic [31:0]         addr_ext;
   logic                addr_ok;
   logic                locked;
   logic                wen_d, ren_d;
   logic [XLEN_DMI-1:0] rsp_data_d;
   logic [1:0]          rsp_status_d;

   // Gated with reset so ready is low while reset is held, even though the
   // state register already sits in IDLE.
   assign dmi_req_ready = reset && (state == ST_IDLE);
   assign dmi_rsp_valid = (state == ST_RESP);
   assign accept        = dmi_req_valid && dmi_req_ready;
   assign in_access     = (state == ST_ACCESS);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:   if (accept) state <= ST_ACCESS;
            ST_ACCESS: state <= ST_RESP;
            ST_RESP:   if (dmi_rsp_ready) state <= ST_IDLE;
            default:   state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         addr_q  <= '0;
         op_q    <= DMI_OP_NOP;
         wdata_q <= '0;
      end else if (accept) begin
         addr_q  <= dmi_req_addr;
         op_q    <= dmi_req_op;
         wdata_q <= dmi_req_data;
      end
   end

   assign reg_addr  = addr_q;
   assign reg_wdata = wdata_q;
   assign addr_ext  = 32'(addr_q);

`ifdef DMI_ADDR_CHECK_EN
   assign addr_ok = is_impl_addr(addr_ext);
`else
   assign addr_ok = 1'b1;
`endif

   // cmd_busy is looked at here, in ACCESS, so a command that starts between
   // acceptance and access still blocks the write.
   assign locked = cmd_busy && is_lock_addr(addr_ext);

   always_comb begin
      wen_d        = 1'b0;
      ren_d        = 1'b0;
      rsp_data_d   = '0;
      rsp_status_d = DMI_RSP_OK;
      if (in_access) begin
         if (!addr_ok) begin
            rsp_status_d = DMI_RSP_FAILED;
         end else begin
            case (op_q)
               DMI_OP_READ: begin
                  ren_d      = 1'b1;
                  rsp_data_d = reg_rdata;
               end
               DMI_OP_WRITE: begin
                  if (locked) rsp_status_d = DMI_RSP_BUSY;
                  else        wen_d        = 1'b1;
               end
               DMI_OP_RSVD: rsp_status_d = DMI_RSP_FAILED;
               default: ;
            endcase
         end
      end
   end

   assign reg_wen = wen_d;
   assign reg_ren = ren_d;

   dm_rsp_reg #(.W(XLEN_DMI)) u_rsp (
      .clk      (clk),
      .reset    (reset),
      .load     (in_access),
      .d_data   (rsp_data_d),
      .d_status (rsp_status_d),
      .q_data   (dmi_rsp_data),
      .q_status (dmi_rsp_status)
   );

endmodule

// File: tb/tb_dm_dmi_frontend.sv
// tb_dm_dmi_frontend: directed + randomized bench for dm_dmi_frontend with a
// transaction-level reference model of the DMI access rules.
module tb_dm_dmi_frontend;

   logic        clk = 1'b0;
   logic        reset;
   logic        dmi_req_valid;
   logic        dmi_req_ready;
   logic [6:0]  dmi_req_addr;
   logic [1:0]  dmi_req_op;
   logic [31:0] dmi_req_data;
   logic        dmi_rsp_valid;
   logic        dmi_rsp_ready;
   logic [31:0] dmi_rsp_data;
   logic [1:0]  dmi_rsp_status;
   logic        cmd_busy;
   logic [6:0]  reg_addr;
   logic        reg_wen;
   logic        reg_ren;
   logic [31:0] reg_wdata;
   logic [31:0] reg_rdata;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   dm_dmi_frontend #(.ABITS(7), .XLEN_DMI(32)) dut (
      .clk(clk), .reset(reset),
      .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
      .dmi_req_addr(dmi_req_addr), .dmi_req_op(dmi_req_op), .dmi_req_data(dmi_req_data),
      .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_ready(dmi_rsp_ready),
      .dmi_rsp_data(dmi_rsp_data), .dmi_rsp_status(dmi_rsp_status),
      .cmd_busy(cmd_busy),
      .reg_addr(reg_addr), .reg_wen(reg_wen), .reg_ren(reg_ren),
      .reg_wdata(reg_wdata), .reg_rdata(reg_rdata)
   );

   // Register-file read model: dmstatus has a fixed value, others a tag of the address.
   function automatic logic [31:0] rf_val(input logic [6:0] a);
      return (a == 7'h11) ? 32'h00400382 : (32'hC0DE0000 | {25'd0, a});
   endfunction

   assign reg_rdata = rf_val(reg_addr);

   // Expected outcome of one transaction from the access rules.
   function automatic void model(input logic [6:0] a, input logic [1:0] op, input logic busy,
                                 output logic wen, output logic ren,
                                 output logic [31:0] d, output logic [1:0] st);
      logic lockr;
      logic impl;
      lockr = (a >= 7'h04 && a <= 7'h0F) || a == 7'h16 || a == 7'h17;
      impl  = lockr || a == 7'h10 || a == 7'h11;
      wen = 1'b0; ren = 1'b0; d = 32'd0; st = 2'd0;
`ifdef DMI_ADDR_CHECK_EN
      if (!impl) begin
         st = 2'd2;
         return;
      end
`else
      if (impl) st = 2'd0;
`endif
      case (op)
         2'd1: begin ren = 1'b1; d = rf_val(a); end
         2'd2: if (busy && lockr) st = 2'd3; else wen = 1'b1;
         2'd3: st = 2'd2;
         default: ;
      endcase
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Runs one transaction; starts and ends at a negedge. cmd_busy is driven
   // to the opposite value at acceptance and flipped in ACCESS, so only the
   // ACCESS-cycle value may matter. hold_next keeps a second request pending
   // during RESP.
   task automatic do_txn(input logic [6:0] a, input logic [1:0] op, input logic [31:0] d,
                         input logic busy, input int delay, input bit hold_next);
      logic ewen, eren;
      logic [31:0] ed;
      logic [1:0] es;
      int n;
      model(a, op, busy, ewen, eren, ed, es);
      n = 0;
      while (dmi_req_ready !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk("req_ready_idle", {31'd0, dmi_req_ready}, 32'd1);
      dmi_req_valid = 1'b1;
      dmi_req_addr  = a;
      dmi_req_op    = op;
      dmi_req_data  = d;
      cmd_busy      = ~busy;
      @(negedge clk);
      dmi_req_valid = 1'b0;
      cmd_busy      = busy;
      #1;
      chk("access_wen",   {31'd0, reg_wen}, {31'd0, ewen});
      chk("access_ren",   {31'd0, reg_ren}, {31'd0, eren});
      chk("access_addr",  {25'd0, reg_addr}, {25'd0, a});
      if (op == 2'd2) chk("access_wdata", reg_wdata, d);
      chk("access_rspv",  {31'd0, dmi_rsp_valid}, 32'd0);
      chk("access_ready", {31'd0, dmi_req_ready}, 32'd0);
      @(negedge clk);
      cmd_busy = 1'b0;
      chk("rsp_valid",  {31'd0, dmi_rsp_valid}, 32'd1);
      chk("rsp_data",   dmi_rsp_data, ed);
      chk("rsp_status", {30'd0, dmi_rsp_status}, {30'd0, es});
      chk("rsp_strobes", {30'd0, reg_wen, reg_ren}, 32'd0);
      if (hold_next) begin
         dmi_req_valid = 1'b1;
         dmi_req_addr  = 7'h11;
         dmi_req_op    = 2'd1;
      end
      for (int i = 0; i < delay; i++) begin
         @(negedge clk);
         chk("hold_valid",  {31'd0, dmi_rsp_valid}, 32'd1);
         chk("hold_data",   dmi_rsp_data, ed);
         chk("hold_status", {30'd0, dmi_rsp_status}, {30'd0, es});
         chk("hold_ready",  {31'd0, dmi_req_ready}, 32'd0);
         chk("hold_strobes", {30'd0, reg_wen, reg_ren}, 32'd0);
      end
      dmi_rsp_ready = 1'b1;
      @(negedge clk);
      dmi_rsp_ready = 1'b0;
      chk("post_rspv",  {31'd0, dmi_rsp_valid}, 32'd0);
      chk("post_ready", {31'd0, dmi_req_ready}, 32'd1);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      logic [6:0] ra;
      reset = 1'b0;
      dmi_req_valid = 1'b0; dmi_req_addr = '0; dmi_req_op = '0; dmi_req_data = '0;
      dmi_rsp_ready = 1'b0; cmd_busy = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_ready",  {31'd0, dmi_req_ready}, 32'd0);
      chk("rst_rspv",   {31'd0, dmi_rsp_valid}, 32'd0);
      chk("rst_data",   dmi_rsp_data, 32'd0);
      chk("rst_status", {30'd0, dmi_rsp_status}, 32'd0);
      chk("rst_strobes", {30'd0, reg_wen, reg_ren}, 32'd0);
      chk("rst_addr",   {25'd0, reg_addr}, 32'd0);
      chk("rst_wdata",  reg_wdata, 32'd0);
      reset = 1'b1;
      @(negedge clk);
      chk("rel_ready", {31'd0, dmi_req_ready}, 32'd1);

      // Directed cases
      do_txn(7'h11, 2'd1, 32'h0, 1'b0, 0, 1'b0);           // read dmstatus
      do_txn(7'h10, 2'd2, 32'h00000001, 1'b0, 0, 1'b0);    // write dmcontrol
      do_txn(7'h17, 2'd2, 32'h00221000, 1'b1, 0, 1'b0);    // command while busy
      do_txn(7'h17, 2'd2, 32'h00221000, 1'b0, 0, 1'b0);    // command idle
      do_txn(7'h04, 2'd1, 32'h0, 1'b1, 0, 1'b0);           // read never locked
      do_txn(7'h16, 2'd2, 32'h0000ABCD, 1'b1, 1, 1'b0);    // abstractcs locked
      do_txn(7'h10, 2'd2, 32'h12345678, 1'b1, 0, 1'b0);    // dmcontrol not lockable
      do_txn(7'h05, 2'd1, 32'h0, 1'b0, 10, 1'b1);          // back-pressure + pending req
      do_txn(7'h0F, 2'd1, 32'h0, 1'b0, 0, 1'b0);           // pending req consumed one cycle later
      do_txn(7'h10, 2'd3, 32'hFFFFFFFF, 1'b0, 0, 1'b0);    // reserved op
      do_txn(7'h00, 2'd0, 32'hDEADBEEF, 1'b0, 0, 1'b0);    // nop
      do_txn(7'h20, 2'd1, 32'h0, 1'b0, 0, 1'b0);           // unimplemented read

      // Randomized transactions against the model
      for (int i = 0; i < 40; i++) begin
         ra = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127))
                                          : 7'($urandom_range(2, 24));
         do_txn(ra, 2'($urandom_range(0, 3)), $urandom, 1'($urandom_range(0, 1)),
                $urandom_range(0, 3), 1'b0);
      end

      // Reset during ACCESS of a write
      dmi_req_valid = 1'b1; dmi_req_addr = 7'h04; dmi_req_op = 2'd2;
      dmi_req_data = 32'hA5A5A5A5; cmd_busy = 1'b0;
      @(negedge clk);
      dmi_req_valid = 1'b0;
      #1;
      chk("pre_rst_wen", {31'd0, reg_wen}, 32'd1);
      reset = 1'b0;
      #1;
      chk("mid_rst_wen",   {31'd0, reg_wen}, 32'd0);
      chk("mid_rst_addr",  {25'd0, reg_addr}, 32'd0);
      chk("mid_rst_wdata", reg_wdata, 32'd0);
      chk("mid_rst_ready", {31'd0, dmi_req_ready}, 32'd0);
      chk("mid_rst_rspv",  {31'd0, dmi_rsp_valid}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         chk("after_rst_rspv",  {31'd0, dmi_rsp_valid}, 32'd0);
         chk("after_rst_ready", {31'd0, dmi_req_ready}, 32'd1);
      end
      do_txn(7'h11, 2'd1, 32'h0, 1'b0, 0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
